wave_xfade_mux: RTL and testbench
=================================

Name: wave_xfade_mux

Overview:
Parametrised N-channel waveform selector for the DDS datapath. It replaces the hard combinational switch with a sample-rate-synchronous crossfade, so a waveform change does not produce a step discontinuity at the DAC. It sits between the waveform generators (sine/saw/pulse/triangle/noise/PWM) and the output stage. All state advances only on the DDS sample strobe.

Parameters:
m, 12, sample width in bits (unsigned)
n_ch, 6, number of waveform input channels (2..16)
fade_log2, 4, crossfade length = 2^fade_log2 samples (1..8)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_en  in  1  one-clk strobe per output sample; all state and output updates gated by it
waves  in  n_ch*m  flattened channel bus; channel i = waves[i*m +: m]
sel  in  $clog2(n_ch)  requested channel; values >= n_ch map to channel 0
wave  out  m  registered output sample
busy  out  1  high while a crossfade is in progress
cur_sel  out  $clog2(n_ch)  channel currently settled on (or faded toward, once complete)

Behaviour:
- One clock domain; reset is synchronous and active-high. Reset: wave=0, busy=0, cur_sel=0, state IDLE, fade counter=0, from/to=0.
- sel_eff = (sel < n_ch) ? sel : 0, evaluated combinationally.
- Nothing changes on clocks without sample_en; wave holds its value.
- IDLE, sample_en, sel_eff == cur_sel: wave <= ch[cur_sel] on the same edge (1-clk latency from strobe).
- IDLE, sample_en, sel_eff != cur_sel: from <= cur_sel, to <= sel_eff, cnt <= 1, state <= FADE, busy <= 1, wave <= blend(ch[from], ch[to], 1).
- FADE, sample_en: cnt <= cnt+1, wave <= blend(..., cnt+1). When cnt+1 == 2^fade_log2, wave = ch[to] exactly, state <= IDLE, busy <= 0, cur_sel <= to.
- blend(a,b,c) = (a*(2^K - c) + b*c) >> K, with K = fade_log2 and c in 1..2^K. Unsigned; intermediate width m+K bits; no overflow is possible; truncate toward zero.
- Live inputs: ch[from] and ch[to] are sampled from waves at each strobe, not frozen.
- sel changes during FADE are ignored. After return to IDLE, a differing sel_eff starts a new fade at the next strobe.
- A fade lasts exactly 2^K strobes. busy is high for strobes 1..2^K-1 and drops on strobe 2^K.
- Reset mid-fade aborts immediately to the reset values.

Optional Feature:
WAVE_XFADE_EN. Defined: crossfade behaviour as above. Undefined: no FADE state and no blend logic. On each sample_en, wave <= ch[sel_eff] and cur_sel <= sel_eff. busy is tied 0.

Decomposition:
- Shared package dds_pkg: waveform select constants SEL_SINE=0, SEL_SAW=1, SEL_PULSE=2, SEL_TRI=3, SEL_NOISE=4, SEL_PWM=5; default sample width 12; fade state encoding (IDLE=0, FADE=1).
- One sub-module: xfade_blend. It is combinational, parametrised on m and fade_log2, and computes blend(a,b,c).
- The FSM, counter and channel extraction stay in wave_xfade_mux.

Test Plan:
- Reset: rst=1 for 2 clks with random waves -> wave=0x000, busy=0, cur_sel=0. Release, no sample_en -> outputs unchanged.
- Steady state: ch0=0x800, sel=0, sample_en every 4th clk -> wave=0x800 one clk after the first strobe; busy=0 throughout.
- Fade (m=12, K=4): ch0=0x000, ch1=0xFF0, sel 0->1 -> successive strobes give wave=0x0FF, 0x1FE, ..., 0xFF0 (0x0FF*c). busy=1 for strobes 1-15, 0 after strobe 16; cur_sel=1.
- Mid-fade change: during a 0->1 fade, set sel=2 at strobe 5 -> 0->1 fade completes unaltered; strobe 17 starts a 1->2 fade (busy=1, wave=blend(ch1,ch2,1)).
- Out of range: n_ch=6, sel=7, cur_sel=3 -> a fade toward channel 0 begins; cur_sel=0 after 16 strobes.
- Reset mid-fade: assert rst at strobe 8 of a fade -> next clk wave=0, busy=0, cur_sel=0. With WAVE_XFADE_EN undefined, sel 0->1 -> wave=ch1 on the first strobe, busy=0.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS constants (waveform select codes, default sample width, crossfade state encoding)
package dds_pkg;

    localparam int SEL_SINE  = 0;
    localparam int SEL_SAW   = 1;
    localparam int SEL_PULSE = 2;
    localparam int SEL_TRI   = 3;
    localparam int SEL_NOISE = 4;
    localparam int SEL_PWM   = 5;

    localparam int DEF_M = 12;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_t;

endpackage

// File: rtl/xfade_blend.sv
// xfade_blend: combinational linear crossfade y = (a*(2^K - c) + b*c) >> K, K = fade_log2, c in 1..2^K
//   a : sample faded away from (m bits)
//   b : sample faded toward (m bits)
//   c : fade position, 2^K selects b exactly (fade_log2+1 bits)
//   y : blended sample (m bits)
module xfade_blend #(
    parameter int m         = 12,
    parameter int fade_log2 = 4
) (
    input  logic [m-1:0]         a,
    input  logic [m-1:0]         b,
    input  logic [fade_log2:0]   c,
    output logic [m-1:0]         y
);

    localparam int aw = m + fade_log2;
    localparam logic [fade_log2:0] full = {1'b1, {fade_log2{1'b0}}};

    logic [fade_log2:0] inv;
    logic [aw-1:0]      acc;

    // The two weights sum to 2^K, so the sum never exceeds (2^m-1)*2^K and fits in m+K bits.
    assign inv = full - c;
    assign acc = aw'(a) * aw'(inv) + aw'(b) * aw'(c);
    assign y   = acc[aw-1:fade_log2];

endmodule

// File: rtl/wave_xfade_mux.sv
// wave_xfade_mux: N-channel waveform selector with sample-synchronous crossfade on channel change
//   Build option: WAVE_XFADE_EN enables the crossfade; when undefined the selector switches directly.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   sample_en : one-clock strobe per output sample; all state updates are gated by it
//   waves     : flattened channel bus, channel i = waves[i*m +: m]
//   sel       : requested channel, values >= n_ch select channel 0
//   wave      : registered output sample
//   busy      : high while a crossfade is in progress
//   cur_sel   : channel currently settled on
module wave_xfade_mux
    import dds_pkg::*;
#(
    parameter int m         = DEF_M,
    parameter int n_ch      = 6,
    parameter int fade_log2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [n_ch*m-1:0]       waves,
    input  logic [$clog2(n_ch)-1:0] sel,
    output logic [m-1:0]            wave,
    output logic                    busy,
    output logic [$clog2(n_ch)-1:0] cur_sel
);

    localparam int sw = $clog2(n_ch);
    localparam logic [sw:0] n_lim = (sw+1)'(n_ch);

    // Channel table padded to a power of two so every sel code indexes a real entry.
    logic [m-1:0]  ch [2**sw];
    logic [sw-1:0] sel_eff;

    genvar i;
    generate
        for (i = 0; i < 2**sw; i++) begin : g_ch
            if (i < n_ch) begin : g_v
                assign ch[i] = waves[i*m +: m];
            end else begin : g_z
                assign ch[i] = '0;
            end
        end
    endgenerate

    assign sel_eff = ({1'b0, sel} < n_lim) ? sel : '0;

`ifdef WAVE_XFADE_EN

    localparam logic [fade_log2:0] one  = {{fade_log2{1'b0}}, 1'b1};
    localparam logic [fade_log2:0] full = {1'b1, {fade_log2{1'b0}}};

    fade_state_t        state;
    logic [sw-1:0]      from;
    logic [sw-1:0]      to;
    logic [fade_log2:0] cnt;
    logic [fade_log2:0] cnt_nx;
    logic [sw-1:0]      a_sel;
    logic [sw-1:0]      b_sel;
    logic [fade_log2:0] c;
    logic [m-1:0]       mix;

    // One blender serves both the first fade step (from IDLE) and the later steps.
    assign cnt_nx = cnt + one;
    assign a_sel  = (state == IDLE) ? cur_sel : from;
    assign b_sel  = (state == IDLE) ? sel_eff : to;
    assign c      = (state == IDLE) ? one : cnt_nx;

    xfade_blend #(
        .m        (m),
        .fade_log2(fade_log2)
    ) u_blend (
        .a(ch[a_sel]),
        .b(ch[b_sel]),
        .c(c),
        .y(mix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wave    <= '0;
            busy    <= 1'b0;
            cur_sel <= '0;
            from    <= '0;
            to      <= '0;
            cnt     <= '0;
        end else if (sample_en) begin
            if (state == IDLE) begin
                if (sel_eff == cur_sel) begin
                    wave <= ch[cur_sel];
                end else begin
                    from  <= cur_sel;
                    to    <= sel_eff;
                    cnt   <= one;
                    state <= FADE;
                    busy  <= 1'b1;
                    wave  <= mix;
                end
            end else begin
                cnt  <= cnt_nx;
                wave <= mix;
                if (cnt_nx == full) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cur_sel <= to;
                end
            end
        end
    end

`else

    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wave    <= '0;
            cur_sel <= '0;
        end else if (sample_en) begin
            wave    <= ch[sel_eff];
            cur_sel <= sel_eff;
        end
    end

`endif

endmodule

// File: tb/tb_wave_xfade_mux.sv
// tb_wave_xfade_mux: self-checking bench for wave_xfade_mux (table vectors, corner sequences, random vs model)
module tb_wave_xfade_mux;

    localparam int M = 12;
    localparam int N = 6;
    localparam int K = 4;
    localparam int F = 1 << K;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_en = 1'b0;
    logic [71:0] waves = '0;
    logic [2:0]  sel = '0;
    logic [11:0] wave;
    logic        busy;
    logic [2:0]  cur_sel;

    int vectors = 0;
    int miscompares = 0;

    int md_wave = 0, md_busy = 0, md_cur = 0, md_from = 0, md_to = 0, md_cnt = 0;

    typedef struct {
        logic        en;
        logic [2:0]  s;
        logic [71:0] w;
        int          ew;
        int          eb;
        int          ec;
    } vec_t;

    vec_t tbl[32];

    always #5 clk = ~clk;

    wave_xfade_mux #(.m(M), .n_ch(N), .fade_log2(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .waves    (waves),
        .sel      (sel),
        .wave     (wave),
        .busy     (busy),
        .cur_sel  (cur_sel)
    );

    function automatic int chv(input logic [71:0] w, input int i);
        return int'(w[i*12 +: 12]);
    endfunction

    function automatic int blend_ref(input int a, input int b, input int c);
        return (a * (F - c) + b * c) / F;
    endfunction

    function automatic logic [71:0] rand_waves();
        logic [71:0] w;
        for (int i = 0; i < N; i++) w[i*12 +: 12] = 12'($urandom_range(0, 4095));
        return w;
    endfunction

    // Reference: a fade is a sequence of F weighted averages from the old to the new channel.
    task automatic model_step(input logic r, input logic en, input logic [2:0] s, input logic [71:0] w);
        int se;
        se = (int'(s) < N) ? int'(s) : 0;
        if (r) begin
            md_wave = 0; md_busy = 0; md_cur = 0; md_from = 0; md_to = 0; md_cnt = 0;
        end else if (en) begin
`ifdef WAVE_XFADE_EN
            if (md_cnt == 0) begin
                if (se == md_cur) begin
                    md_wave = chv(w, md_cur);
                end else begin
                    md_from = md_cur;
                    md_to   = se;
                    md_cnt  = 1;
                    md_busy = 1;
                    md_wave = blend_ref(chv(w, md_from), chv(w, md_to), 1);
                end
            end else begin
                md_cnt  = md_cnt + 1;
                md_wave = blend_ref(chv(w, md_from), chv(w, md_to), md_cnt);
                if (md_cnt == F) begin
                    md_cnt  = 0;
                    md_busy = 0;
                    md_cur  = md_to;
                end
            end
`else
            md_wave = chv(w, se);
            md_cur  = se;
`endif
        end
    endtask

    task automatic tick(input logic r, input logic en, input logic [2:0] s, input logic [71:0] w);
        @(negedge clk);
        rst = r;
        sample_en = en;
        sel = s;
        waves = w;
        @(posedge clk);
        model_step(r, en, s, w);
        #1;
    endtask

    task automatic cmp(input string name, input int ew, input int eb, input int ec);
        vectors++;
        if (int'(wave) != ew || int'(busy) != eb || int'(cur_sel) != ec) begin
            miscompares++;
            $display("FAIL %s: got wave=%03h busy=%0d cur_sel=%0d, want wave=%03h busy=%0d cur_sel=%0d",
                     name, wave, busy, cur_sel, ew, eb, ec);
        end
    endtask

    initial begin
        logic [71:0] w;
        logic [2:0]  s;
        logic        r;
        logic        en;

        // Build the vector table from reset using the reference model.
        model_step(1'b1, 1'b0, 3'd0, '0);
        s = 3'd0;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 1) == 0) s = 3'($urandom_range(0, 7));
            tbl[i].en = ($urandom_range(0, 3) != 0);
            tbl[i].s  = s;
            tbl[i].w  = rand_waves();
            model_step(1'b0, tbl[i].en, tbl[i].s, tbl[i].w);
            tbl[i].ew = md_wave;
            tbl[i].eb = md_busy;
            tbl[i].ec = md_cur;
        end

        // Reset and hold
        tick(1'b1, 1'b0, 3'd0, rand_waves());
        tick(1'b1, 1'b0, 3'd0, rand_waves());
        cmp("reset", 0, 0, 0);
        tick(1'b0, 1'b0, 3'd0, rand_waves());
        cmp("hold_no_strobe", 0, 0, 0);
        tick(1'b0, 1'b0, 3'd0, rand_waves());
        cmp("hold_no_strobe", 0, 0, 0);

        // Steady state on channel 0, strobe every 4th clock
        w = rand_waves();
        w[11:0] = 12'h800;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick(1'b0, 1'b0, 3'd0, w);
                cmp("steady_idle", (k == 0) ? 0 : 'h800, 0, 0);
            end
            tick(1'b0, 1'b1, 3'd0, w);
            cmp("steady_strobe", 'h800, 0, 0);
        end

        // Table vectors
        tick(1'b1, 1'b0, 3'd0, rand_waves());
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, tbl[i].en, tbl[i].s, tbl[i].w);
            cmp("table", tbl[i].ew, tbl[i].eb, tbl[i].ec);
        end

`ifdef WAVE_XFADE_EN
        // Full 0->1 ramp: 0x0FF per step
        tick(1'b1, 1'b0, 3'd0, '0);
        w = rand_waves();
        w[11:0]  = 12'h000;
        w[23:12] = 12'hFF0;
        for (int c = 1; c <= F; c++) begin
            tick(1'b0, 1'b1, 3'd1, w);
            cmp("fade_ramp", 'hFF * c, (c < F) ? 1 : 0, (c == F) ? 1 : 0);
            tick(1'b0, 1'b0, 3'd1, w);
            cmp("fade_hold", 'hFF * c, (c < F) ? 1 : 0, (c == F) ? 1 : 0);
        end

        // sel change mid-fade is ignored, then starts a new fade
        tick(1'b1, 1'b0, 3'd0, '0);
        w = rand_waves();
        for (int c = 1; c <= F; c++) begin
            tick(1'b0, 1'b1, (c >= 5) ? 3'd2 : 3'd1, w);
            cmp("midfade_sel", blend_ref(chv(w, 0), chv(w, 1), c), (c < F) ? 1 : 0, (c == F) ? 1 : 0);
        end
        tick(1'b0, 1'b1, 3'd2, w);
        cmp("midfade_restart", blend_ref(chv(w, 1), chv(w, 2), 1), 1, 1);

        // Out-of-range sel fades toward channel 0
        tick(1'b1, 1'b0, 3'd0, '0);
        w = rand_waves();
        for (int c = 1; c <= F; c++) tick(1'b0, 1'b1, 3'd3, w);
        cmp("oor_setup", chv(w, 3), 0, 3);
        for (int c = 1; c <= F; c++) begin
            tick(1'b0, 1'b1, 3'd7, w);
            cmp("oor_fade", blend_ref(chv(w, 3), chv(w, 0), c), (c < F) ? 1 : 0, (c == F) ? 0 : 3);
        end

        // Reset aborts a fade
        tick(1'b1, 1'b0, 3'd0, '0);
        w = rand_waves();
        for (int c = 1; c <= 8; c++) tick(1'b0, 1'b1, 3'd1, w);
        cmp("rst_mid_pre", blend_ref(chv(w, 0), chv(w, 1), 8), 1, 0);
        tick(1'b1, 1'b1, 3'd1, w);
        cmp("rst_mid", 0, 0, 0);
`else
        // Direct switching
        tick(1'b1, 1'b0, 3'd0, '0);
        w = rand_waves();
        tick(1'b0, 1'b1, 3'd0, w);
        cmp("direct_ch0", chv(w, 0), 0, 0);
        tick(1'b0, 1'b1, 3'd1, w);
        cmp("direct_switch", chv(w, 1), 0, 1);
        tick(1'b0, 1'b0, 3'd5, rand_waves());
        cmp("direct_hold", chv(w, 1), 0, 1);
        tick(1'b0, 1'b1, 3'd7, w);
        cmp("direct_oor", chv(w, 0), 0, 0);
        tick(1'b0, 1'b1, 3'd5, w);
        cmp("direct_ch5", chv(w, 5), 0, 5);
        tick(1'b1, 1'b1, 3'd3, w);
        cmp("direct_rst", 0, 0, 0);
`endif

        // Random stimulus with live-changing inputs against the model
        s = 3'd0;
        w = rand_waves();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 2) s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 3) w = rand_waves();
            tick(r, en, s, w);
            cmp("random", md_wave, md_busy, md_cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
